gauss_kernel_gen: RTL and testbench
===================================

Name: gauss_kernel_gen

Overview:
- Synthesisable, parametrised Gaussian kernel generator for the blur stage ahead of the FAST detector.
- Uses integer arithmetic only, with no real types.
- Builds an odd-sized NxN kernel as the outer product of a 1D Gaussian vector taken from an elaboration-time ROM.
- Computes one quadrant only and mirrors it into the other three; accumulates the kernel sum; commits kernel and sum atomically with a done pulse.

Parameters:
- MAX_KERNEL, 7, largest supported kernel side; must be odd and >= 3.
- COEF_W, 8, coefficient width; 1D and 2D entries are unsigned COEF_W bits.
- SIGMA_W, 3, width of the sigma input; valid sigma is 1..2^SIGMA_W-1.
- SUM_W, COEF_W+2*$clog2(MAX_KERNEL), width of the kernel-sum output.

Ports:
- clk  in  1  clock; all logic on rising edge.
- n_rst  in  1  reset; synchronous, active-low.
- start  in  1  request generation; sampled only in IDLE.
- sigma  in  SIGMA_W  Gaussian sigma, integer.
- kernel_size  in  $clog2(MAX_KERNEL)+1  kernel side N; odd, 1..MAX_KERNEL.
- busy  out  1  high from the cycle after start is accepted until done.
- kernel  out  [MAX_KERNEL][MAX_KERNEL][COEF_W]  committed kernel [y][x]; entries outside NxN are 0.
- sum  out  SUM_W  sum of all committed kernel entries.
- done  out  1  one-cycle pulse when kernel/sum are committed.
- err  out  1  one-cycle pulse when start is rejected for bad arguments.

Behaviour:
- Reset (n_rst low at a clock edge): FSM returns to IDLE; kernel, shadow array, sum, busy, done and err all go to 0. Reset mid-generation aborts the run; no partial commit.
- ROM: g[s][d] = round((2^COEF_W-1)*exp(-d^2/(2*s^2))) for s in 1..2^SIGMA_W-1 and d in 0..(MAX_KERNEL-1)/2. Filled at elaboration by a constant function.
- ROM values at COEF_W=8:
  - s=1: 255, 155, 35, 3.
  - s=2: 255, 225, 155, 83.
- 2D entry: e(i,j) = (g[i]*g[j] + 2^(COEF_W-1)) >> COEF_W, truncated to COEF_W bits. Product width is 2*COEF_W, with no overflow.
- c = (N-1)/2. Quadrant indices i,j run 0..c, where the offset from centre is c-i.
- FSM states:
  - IDLE:
    - Accepts start.
    - If sigma==0, N even, N==0 or N>MAX_KERNEL: pulse err next cycle, stay in IDLE, leave outputs unchanged.
    - Otherwise: latch sigma and N, clear the shadow array and the accumulator, assert busy, go to LOAD.
  - LOAD:
    - c+1 cycles; cycle k loads gvec[k] = g[sigma][k].
    - Then go to QUAD.
  - QUAD:
    - (c+1)^2 cycles, raster order j outer, i inner.
    - Each cycle computes e(c-i,c-j) and writes it to shadow positions (c±dx, c±dy), with dx=c-i and dy=c-j.
    - Accumulator adds e times multiplicity: 1 if dx=dy=0; 2 if exactly one is 0; 4 otherwise.
  - COMMIT:
    - One cycle: kernel <= shadow, sum <= accumulator, done=1, busy=0.
    - Return to IDLE.
- Latency: done is high in the cycle following the (c+1)+(c+1)^2+1-th rising edge after the edge that samples start. This gives N=3: 7 edges; N=7: 21 edges.
- start while busy is ignored, with no queueing. start in the COMMIT cycle is also ignored.
- A new start may be accepted in the cycle after done.
- kernel and sum hold their last committed values during a run and change only in COMMIT.
- err and done are never asserted in the same cycle.

Optional Feature:
- Macro: GAUSS_KERNEL_SEP_OUT_EN.
- When defined:
  - Adds output row_vec [MAX_KERNEL][COEF_W], the full symmetric 1D vector g mirrored about the centre, 0 outside N.
  - Adds output row_sum [COEF_W+$clog2(MAX_KERNEL)-1:0], its sum.
  - Both are committed in the same COMMIT cycle as kernel and reset to 0, for downstream separable convolution.
- When undefined: the ports and their registers do not exist. All other behaviour and latency are unchanged.

Test Plan:
- Reset, then sigma=1, N=3, start for 1 cycle:
  - done at edge 7.
  - Kernel centre 254; edges 154; corners 94; sum=1246.
  - All other entries 0; busy high for 6 cycles.
- sigma=1, N=1:
  - done at edge 3; kernel[0][0]=254; sum=254; all others 0.
- Bad arguments: sigma=0, N=3 start -> err pulse, no busy, no done, kernel/sum unchanged. Repeat with N=4 and N=9 -> err each time.
- Reprogramming:
  - Run sigma=1 N=3, then sigma=2 N=7.
  - Kernel values hold until the second done at edge 21.
  - Every new entry equals its 180° and mirror counterparts; centre 254.
  - All 49 entries nonzero.
- Start while busy:
  - Pulse start again at edge 3 of a run -> ignored; a single done.
  - Start at the cycle after done -> accepted.
- Reset mid-run: n_rst low at edge 4 of an N=7 run -> kernel/sum/busy return to 0 and no done appears.
- With GAUSS_KERNEL_SEP_OUT_EN, sigma=2 N=7: row_vec = 83,155,225,255,225,155,83; row_sum=1181.

Source files
------------

// File: rtl/gauss_kernel_gen.sv
// Gaussian kernel generator: builds one quadrant from a 1D ROM vector, mirrors it to NxN, commits kernel+sum.
// Optional macro GAUSS_KERNEL_SEP_OUT_EN adds the mirrored 1D vector (row_vec) and its sum (row_sum).
module gauss_kernel_gen #(
  parameter int MAX_KERNEL = 7,
  parameter int COEF_W     = 8,
  parameter int SIGMA_W    = 3,
  parameter int SUM_W      = COEF_W + 2*$clog2(MAX_KERNEL)
) (
  input  logic                                           clk,
  input  logic                                           n_rst,
  input  logic                                           start,
  input  logic [SIGMA_W-1:0]                             sigma,
  input  logic [$clog2(MAX_KERNEL):0]                    kernel_size,
  output logic                                           busy,
  output logic [MAX_KERNEL-1:0][MAX_KERNEL-1:0][COEF_W-1:0] kernel,
  output logic [SUM_W-1:0]                               sum,
  output logic                                           done,
  output logic                                           err,
`ifdef GAUSS_KERNEL_SEP_OUT_EN
  output logic [MAX_KERNEL-1:0][COEF_W-1:0]              row_vec,
  output logic [COEF_W+$clog2(MAX_KERNEL)-1:0]           row_sum,
`endif
  output logic [1:0]                                     dbg_state
);

  localparam int C_MAX = (MAX_KERNEL - 1) / 2;
  localparam int ND    = C_MAX + 1;
  localparam int NS    = 2**SIGMA_W;
  localparam int CW    = (ND > 1) ? $clog2(ND) : 1;
  localparam int KW    = $clog2(MAX_KERNEL) + 1;
  localparam int IW    = $clog2(MAX_KERNEL);
  localparam int PW    = 2 * COEF_W;
  localparam int RSW   = COEF_W + $clog2(MAX_KERNEL);

  typedef logic [NS-1:0][ND-1:0][COEF_W-1:0] rom_t;
  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_QUAD, S_COMMIT} state_t;

  // exp(-x) in Q30: Taylor series on x/16, then squared four times to undo the scaling.
  function automatic logic [COEF_W-1:0] gauss_coef(input int s, input int d);
    logic [63:0] one;
    logic [63:0] x;
    logic [63:0] t;
    logic [63:0] acc;
    one = 64'd1 << 30;
    x   = (64'(d * d) << 30) / 64'(32 * s * s);
    acc = one;
    t   = one;
    for (int n = 1; n <= 8; n++) begin
      t = ((t * x) >> 30) / 64'(n);
      if ((n % 2) == 1) acc = acc - t;
      else              acc = acc + t;
    end
    for (int k = 0; k < 4; k++) acc = (acc * acc) >> 30;
    return COEF_W'((64'((1 << COEF_W) - 1) * acc + (one >> 1)) >> 30);
  endfunction

  function automatic rom_t build_rom();
    rom_t rom;
    rom = '0;
    for (int s = 1; s < NS; s++)
      for (int d = 0; d < ND; d++)
        rom[s][d] = gauss_coef(s, d);
    return rom;
  endfunction

  localparam rom_t G_ROM = build_rom();

  state_t                                            r_state;
  state_t                                            w_state_nxt;
  logic [SIGMA_W-1:0]                                r_sigma;
  logic [CW-1:0]                                     r_c;
  logic [CW-1:0]                                     r_i;
  logic [CW-1:0]                                     r_j;
  logic [ND-1:0][COEF_W-1:0]                         r_gvec;
  logic [MAX_KERNEL-1:0][MAX_KERNEL-1:0][COEF_W-1:0] r_shadow;
  logic [MAX_KERNEL-1:0][MAX_KERNEL-1:0][COEF_W-1:0] r_kernel;
  logic [SUM_W-1:0]                                  r_acc;
  logic [SUM_W-1:0]                                  r_sum;
  logic                                              r_busy;
  logic                                              r_done;
  logic                                              r_err;

  logic              w_args_ok;
  logic              w_accept;
  logic              w_reject;
  logic [CW-1:0]     w_c_in;
  logic [CW-1:0]     w_dx;
  logic [CW-1:0]     w_dy;
  logic [PW-1:0]     w_prod;
  logic [COEF_W-1:0] w_e;
  logic [SUM_W-1:0]  w_add;
  logic [IW-1:0]     w_xp;
  logic [IW-1:0]     w_xm;
  logic [IW-1:0]     w_yp;
  logic [IW-1:0]     w_ym;

  assign w_args_ok = (sigma != '0) && kernel_size[0] && (kernel_size <= KW'(MAX_KERNEL));
  assign w_c_in    = CW'(kernel_size >> 1);

  always_ff @(posedge clk) begin
    if (!n_rst) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_reject    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          if (w_args_ok) begin
            w_accept    = 1'b1;
            w_state_nxt = S_LOAD;
          end else begin
            w_reject    = 1'b1;
          end
        end
      end
      S_LOAD:   if (r_i == r_c) w_state_nxt = S_QUAD;
      S_QUAD:   if ((r_i == r_c) && (r_j == r_c)) w_state_nxt = S_COMMIT;
      S_COMMIT: w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // Quadrant point (i,j) maps to offsets (dx,dy) from centre; its value lands in up to four mirrored cells.
  always_comb begin
    w_dx   = r_c - r_i;
    w_dy   = r_c - r_j;
    w_prod = PW'(r_gvec[w_dx]) * PW'(r_gvec[w_dy]);
    w_e    = COEF_W'((w_prod + PW'(2**(COEF_W-1))) >> COEF_W);
    if ((w_dx == '0) && (w_dy == '0))      w_add = SUM_W'(w_e);
    else if ((w_dx == '0) || (w_dy == '0)) w_add = SUM_W'(w_e) << 1;
    else                                   w_add = SUM_W'(w_e) << 2;
    w_xp   = IW'(r_c) + IW'(w_dx);
    w_xm   = IW'(r_c) - IW'(w_dx);
    w_yp   = IW'(r_c) + IW'(w_dy);
    w_ym   = IW'(r_c) - IW'(w_dy);
  end

`ifdef GAUSS_KERNEL_SEP_OUT_EN
  logic [MAX_KERNEL-1:0][COEF_W-1:0] r_row_vec;
  logic [RSW-1:0]                    r_row_sum;
  logic [MAX_KERNEL-1:0][COEF_W-1:0] w_row_vec;
  logic [RSW-1:0]                    w_row_sum;

  function automatic logic [CW-1:0] dist(input int x, input int c);
    return CW'((x <= c) ? (c - x) : (x - c));
  endfunction

  always_comb begin
    w_row_vec = '0;
    w_row_sum = '0;
    for (int x = 0; x < MAX_KERNEL; x++) begin
      if (x <= 2 * int'(r_c)) begin
        w_row_vec[x] = r_gvec[dist(x, int'(r_c))];
        w_row_sum    = w_row_sum + RSW'(r_gvec[dist(x, int'(r_c))]);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      r_row_vec <= '0;
      r_row_sum <= '0;
    end else if (r_state == S_COMMIT) begin
      r_row_vec <= w_row_vec;
      r_row_sum <= w_row_sum;
    end
  end

  assign row_vec = r_row_vec;
  assign row_sum = r_row_sum;
`endif

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      r_sigma  <= '0;
      r_c      <= '0;
      r_i      <= '0;
      r_j      <= '0;
      r_gvec   <= '0;
      r_shadow <= '0;
      r_kernel <= '0;
      r_acc    <= '0;
      r_sum    <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_busy <= (w_state_nxt == S_LOAD) || (w_state_nxt == S_QUAD);
      r_done <= (r_state == S_COMMIT);
      r_err  <= w_reject;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_sigma  <= sigma;
            r_c      <= w_c_in;
            r_i      <= '0;
            r_j      <= '0;
            r_shadow <= '0;
            r_acc    <= '0;
          end
        end
        S_LOAD: begin
          r_gvec[r_i] <= G_ROM[r_sigma][r_i];
          r_i         <= (r_i == r_c) ? '0 : r_i + CW'(1);
        end
        S_QUAD: begin
          r_shadow[w_yp][w_xp] <= w_e;
          r_shadow[w_yp][w_xm] <= w_e;
          r_shadow[w_ym][w_xp] <= w_e;
          r_shadow[w_ym][w_xm] <= w_e;
          r_acc                <= r_acc + w_add;
          if (r_i == r_c) begin
            r_i <= '0;
            r_j <= r_j + CW'(1);
          end else begin
            r_i <= r_i + CW'(1);
          end
        end
        S_COMMIT: begin
          r_kernel <= r_shadow;
          r_sum    <= r_acc;
        end
        default: ;
      endcase
    end
  end

  assign busy      = r_busy;
  assign kernel    = r_kernel;
  assign sum       = r_sum;
  assign done      = r_done;
  assign err       = r_err;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_gauss_kernel_gen.sv
// Scoreboard bench for gauss_kernel_gen: a real-valued Gaussian reference fills an expected queue,
// a negedge monitor pops and compares on every done/err pulse and checks outputs hold between commits.
`timescale 1ns/1ps
module tb_gauss_kernel_gen;
  localparam int MK   = 7;
  localparam int CWD  = 8;
  localparam int SW   = 3;
  localparam int SUMW = CWD + 2*$clog2(MK);
  localparam int KSW  = $clog2(MK) + 1;
  localparam int RSW  = CWD + $clog2(MK);

  typedef logic [MK-1:0][MK-1:0][CWD-1:0] kern_t;
  typedef struct packed {
    logic                   is_err;
    logic [31:0]            cyc;
    kern_t                  k;
    logic [SUMW-1:0]        s;
    logic [MK-1:0][CWD-1:0] rv;
    logic [RSW-1:0]         rs;
  } exp_t;

  // clock / reset
  logic clk = 1'b0;
  logic n_rst;
  always #5 clk = ~clk;
  int unsigned cyc = 0;
  always @(posedge clk) cyc++;

  logic            start;
  logic [SW-1:0]   sigma;
  logic [KSW-1:0]  kernel_size;
  logic            busy;
  kern_t           kernel;
  logic [SUMW-1:0] sum;
  logic            done;
  logic            err;
  logic [1:0]      dbg_state;
`ifdef GAUSS_KERNEL_SEP_OUT_EN
  logic [MK-1:0][CWD-1:0] row_vec;
  logic [RSW-1:0]         row_sum;
`endif

  gauss_kernel_gen #(.MAX_KERNEL(MK), .COEF_W(CWD), .SIGMA_W(SW)) dut (
    .clk(clk), .n_rst(n_rst), .start(start), .sigma(sigma), .kernel_size(kernel_size),
    .busy(busy), .kernel(kernel), .sum(sum), .done(done), .err(err),
`ifdef GAUSS_KERNEL_SEP_OUT_EN
    .row_vec(row_vec), .row_sum(row_sum),
`endif
    .dbg_state(dbg_state)
  );

  // scoreboard state
  exp_t                   exp_q[$];
  kern_t                  held_k = '0;
  logic [SUMW-1:0]        held_s = '0;
  logic [MK-1:0][CWD-1:0] held_rv = '0;
  logic [RSW-1:0]         held_rs = '0;
  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // reference model straight from the Gaussian formula
  function automatic int g_ref(input int s, input int d);
    return $rtoi(255.0 * $exp(-real'(d * d) / (2.0 * real'(s * s))) + 0.5);
  endfunction

  function automatic exp_t model(input int s, input int n, input logic [31:0] t);
    exp_t e;
    int c, dx, dy, v;
    e = '0;
    c = (n - 1) / 2;
    for (int y = 0; y < n; y++) begin
      for (int x = 0; x < n; x++) begin
        dx = (x > c) ? x - c : c - x;
        dy = (y > c) ? y - c : c - y;
        v  = (g_ref(s, dx) * g_ref(s, dy) + 128) / 256;
        e.k[y][x] = CWD'(v);
        e.s = e.s + SUMW'(v);
      end
    end
    for (int x = 0; x < n; x++) begin
      dx = (x > c) ? x - c : c - x;
      e.rv[x] = CWD'(g_ref(s, dx));
      e.rs = e.rs + RSW'(g_ref(s, dx));
    end
    e.cyc = t + 32'((c + 1) + (c + 1) * (c + 1) + 1);
    return e;
  endfunction

  // monitor
  always @(negedge clk) begin : mon
    exp_t e;
    if (n_rst === 1'b1) begin
      if (done && err) chk("done_err_overlap", 1, 0);
      if (done || err) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_output", {done, err}, 0);
        end else begin
          e = exp_q.pop_front();
          chk("out_kind_err", err, e.is_err);
          chk("out_cycle", cyc, e.cyc);
          if (!e.is_err) begin
            chk("commit_kernel", kernel, e.k);
            chk("commit_sum", sum, e.s);
`ifdef GAUSS_KERNEL_SEP_OUT_EN
            chk("commit_row_vec", row_vec, e.rv);
            chk("commit_row_sum", row_sum, e.rs);
            held_rv = e.rv;
            held_rs = e.rs;
`endif
            held_k = e.k;
            held_s = e.s;
          end
        end
      end
      if (!done) begin
        chk("hold_kernel", kernel, held_k);
        chk("hold_sum", sum, held_s);
`ifdef GAUSS_KERNEL_SEP_OUT_EN
        chk("hold_row_vec", row_vec, held_rv);
        chk("hold_row_sum", row_sum, held_rs);
`endif
      end
    end
  end

  // driver tasks
  task automatic do_reset();
    n_rst = 1'b0;
    @(posedge clk);
    #1;
    exp_q.delete();
    held_k = '0; held_s = '0; held_rv = '0; held_rs = '0;
    @(negedge clk);
    n_rst = 1'b1;
  endtask

  task automatic issue(input int s, input int n, output logic [31:0] t, output logic ok);
    exp_t e;
    sigma = SW'(s);
    kernel_size = KSW'(n);
    start = 1'b1;
    t  = cyc + 1;
    ok = (s != 0) && ((n % 2) == 1) && (n <= MK);
    if (ok) begin
      e = model(s, n, t);
    end else begin
      e = '0;
      e.is_err = 1'b1;
      e.cyc = t;
    end
    exp_q.push_back(e);
    @(negedge clk);
    start = 1'b0;
    sigma = SW'($urandom_range(0, 7));
    kernel_size = KSW'($urandom_range(0, 15));
  endtask

  // poke != 0: a valid start is raised so the DUT samples it at edge t+poke (must be ignored)
  task automatic run(input int s, input int n, input int poke);
    logic [31:0] t;
    logic ok;
    int nb, c;
    issue(s, n, t, ok);
    c  = (n - 1) / 2;
    nb = 0;
    if (ok) begin
      for (int k = 0; k < 60 && !done; k++) begin
        if (busy) nb++;
        if (poke != 0 && cyc == t + 32'(poke) - 1) begin
          start = 1'b1;
          sigma = SW'($urandom_range(1, 7));
          kernel_size = KSW'(2 * $urandom_range(0, 3) + 1);
        end else begin
          start = 1'b0;
        end
        @(negedge clk);
      end
      start = 1'b0;
      chk("done_seen", done, 1);
      chk("busy_cycles", nb, (c + 1) + (c + 1) * (c + 1));
    end else begin
      for (int k = 0; k < 4; k++) begin
        chk("reject_busy", busy, 0);
        chk("reject_done", done, 0);
        @(negedge clk);
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] t;
    logic ok;
    int nz, nd;
    int rv_exp[7];
    n_rst = 1'b0; start = 1'b0; sigma = '0; kernel_size = '0;
    repeat (3) @(negedge clk);
    do_reset();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_kernel", kernel, 0);
    chk("rst_sum", sum, 0);

    run(1, 3, 0);
    chk("n3_centre", kernel[1][1], 254);
    chk("n3_edge", kernel[0][1], 154);
    chk("n3_corner", kernel[2][2], 94);
    chk("n3_sum", sum, 1246);
    chk("n3_outside", kernel[3][3], 0);

    run(1, 1, 0);
    chk("n1_entry", kernel[0][0], 254);
    chk("n1_sum", sum, 254);

    run(0, 3, 0);
    run(1, 4, 0);
    run(1, 9, 0);

    run(1, 3, 3);
    run(1, 1, 3);
    run(1, 3, 0);
    run(2, 7, 0);
    chk("n7_centre", kernel[3][3], 254);
    nz = 0;
    for (int y = 0; y < MK; y++)
      for (int x = 0; x < MK; x++)
        if (kernel[y][x] != '0) nz++;
    chk("n7_nonzero", nz, 49);
`ifdef GAUSS_KERNEL_SEP_OUT_EN
    rv_exp = '{83, 155, 225, 255, 225, 155, 83};
    for (int x = 0; x < MK; x++) chk("sep_row_vec", row_vec[x], rv_exp[x]);
    chk("sep_row_sum", row_sum, 1181);
`else
    rv_exp = '{0, 0, 0, 0, 0, 0, 0};
`endif

    // reset at edge 4 of an N=7 run
    issue(2, 7, t, ok);
    repeat (3) @(negedge clk);
    do_reset();
    chk("midrst_busy", busy, 0);
    chk("midrst_kernel", kernel, 0);
    chk("midrst_sum", sum, 0);
    nd = 0;
    for (int k = 0; k < 30; k++) begin
      if (done) nd++;
      @(negedge clk);
    end
    chk("midrst_no_done", nd, 0);

    for (int r = 0; r < 30; r++) begin
      run($urandom_range(0, 7), $urandom_range(0, 9),
          ($urandom_range(0, 2) == 0) ? $urandom_range(1, 8) : 0);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
    end

    repeat (5) @(negedge clk);
    chk("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
